adder_share_arbiter: RTL and testbench

//   Shares one registered wide adder between NUM_REQ requesters.
//   - Round-robin arbiter accepts at most one operand pair per cycle.
//   - Two-stage pipeline computes the sum: operand register, then sum register.
//   - Each sum returns tagged with the requester's ID, with global backpressure.
//   - Sits between the datapath clients and the adder_top-style datapath in arithmetic benchmarks.

---
 rtl/adder_share_arbiter.sv | 129 ++++++++++++
 tb/tb_adder_share_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one two-stage registered adder between NUM_REQ requesters.
// Define ADDER_ARB_STATS_EN to add the stat_accepts / stat_stalls counters.
module adder_share_arbiter #(
  parameter int unsigned ADDER_WIDTH = 127,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [ADDER_WIDTH:0]           rsp_sum,
  input  logic                           rsp_ready
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [31:0]                    stat_accepts,
  output logic [31:0]                    stat_stalls
`endif
);

  logic                   w_stall;
  logic                   w_found;
  logic                   w_accept;
  logic [ID_WIDTH-1:0]    w_win_id;
  logic [ID_WIDTH-1:0]    w_ptr_next;
  logic [NUM_REQ-1:0]     w_grant;
  logic [ADDER_WIDTH-1:0] w_a;
  logic [ADDER_WIDTH-1:0] w_b;
  logic [ADDER_WIDTH:0]   w_sum;

  logic [ID_WIDTH-1:0]    r_ptr;
  logic                   r_s1_valid;
  logic [ID_WIDTH-1:0]    r_s1_id;
  logic [ADDER_WIDTH-1:0] r_s1_a;
  logic [ADDER_WIDTH-1:0] r_s1_b;
  logic                   r_rsp_valid;
  logic [ID_WIDTH-1:0]    r_rsp_id;
  logic [ADDER_WIDTH:0]   r_rsp_sum;

  assign w_stall = r_rsp_valid & ~rsp_ready;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req_valid[j] && (ID_WIDTH'(j) >= r_ptr)) begin
        w_found  = 1'b1;
        w_win_id = ID_WIDTH'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_found && req_valid[j] && (ID_WIDTH'(j) < r_ptr)) begin
        w_found  = 1'b1;
        w_win_id = ID_WIDTH'(j);
      end
    end
  end

  assign w_accept = w_found & ~w_stall & rst_n;

  always_comb begin
    w_grant = '0;
    w_a     = '0;
    w_b     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win_id == ID_WIDTH'(j)) begin
        w_grant[j] = w_accept;
        w_a        = req_a[j*ADDER_WIDTH +: ADDER_WIDTH];
        w_b        = req_b[j*ADDER_WIDTH +: ADDER_WIDTH];
      end
    end
  end

  assign w_ptr_next = (w_win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;
  assign w_sum      = {1'b0, r_s1_a} + {1'b0, r_s1_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_id     <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_ptr   <= w_ptr_next;
        r_s1_id <= w_win_id;
        r_s1_a  <= w_a;
        r_s1_b  <= w_b;
      end
      r_rsp_valid <= r_s1_valid;
      r_rsp_id    <= r_s1_id;
      r_rsp_sum   <= w_sum;
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;

`ifdef ADDER_ARB_STATS_EN
  logic [31:0] r_stat_accepts;
  logic [31:0] r_stat_stalls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_accepts <= '0;
      r_stat_stalls  <= '0;
    end else begin
      if (w_accept) r_stat_accepts <= r_stat_accepts + 32'd1;
      if (w_stall)  r_stat_stalls  <= r_stat_stalls + 32'd1;
    end
  end

  assign stat_accepts = r_stat_accepts;
  assign stat_stalls  = r_stat_stalls;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (optionally with ADDER_ARB_STATS_EN).
module tb_adder_share_arbiter;
  localparam int unsigned W  = 127;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_a;
  logic [N*W-1:0]   req_b;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic [IW-1:0]    rsp_id;
  logic [W:0]       rsp_sum;
  logic             rsp_ready;
`ifdef ADDER_ARB_STATS_EN
  logic [31:0]      stat_accepts;
  logic [31:0]      stat_stalls;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  adder_share_arbiter #(
    .ADDER_WIDTH (W),
    .NUM_REQ     (N),
    .ID_WIDTH    (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_ready    (rsp_ready)
`ifdef ADDER_ARB_STATS_EN
    ,
    .stat_accepts (stat_accepts),
    .stat_stalls  (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  logic [W:0] carry_sum;

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    carry_sum = {{W{1'b1}}, 1'b0};
    #2;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    tick();
    tick();
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_id", 128'(rsp_id), 128'd0);
    chk("rst_rsp_sum", 128'(rsp_sum), 128'd0);
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single op from requester 0
    set_op(0, 127'd5, 127'd7);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 128'(req_ready), 128'b0001);
    tick();
    req_valid = '0;
    chk("single_lat1_valid", 128'(rsp_valid), 128'd0);
    tick();
    chk("single_valid", 128'(rsp_valid), 128'd1);
    chk("single_id", 128'(rsp_id), 128'd0);
    chk("single_sum", 128'(rsp_sum), 128'd12);

    // Full-width carry from requester 1 (pointer now 1)
    set_op(1, {W{1'b1}}, {W{1'b1}});
    req_valid = 4'b0010;
    #1;
    chk("carry_ready", 128'(req_ready), 128'b0010);
    tick();
    req_valid = '0;
    tick();
    chk("carry_valid", 128'(rsp_valid), 128'd1);
    chk("carry_id", 128'(rsp_id), 128'd1);
    chk("carry_sum", 128'(rsp_sum), 128'(carry_sum));

    // Reset mid-flight with two ops accepted (pointer now 2)
    set_op(2, 127'd1, 127'd1);
    req_valid = 4'b0100;
    #1;
    chk("mid_ready0", 128'(req_ready), 128'b0100);
    tick();
    set_op(3, 127'd2, 127'd2);
    req_valid = 4'b1000;
    #1;
    chk("mid_ready1", 128'(req_ready), 128'b1000);
    tick();
    req_valid = '0;
    chk("mid_pre_valid", 128'(rsp_valid), 128'd1);
    chk("mid_pre_sum", 128'(rsp_sum), 128'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(rsp_valid), 128'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_post_valid", 128'(rsp_valid), 128'd0);
    end

    // Round robin, all requesters valid; pointer must be back at 0
    for (int i = 0; i < 4; i++) set_op(i, W'(100 + i), W'(2 * i));
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_ready", 128'(req_ready), 128'(4'b0001 << (c % 4)));
      tick();
      if (c == 0) begin
        chk("rr_valid0", 128'(rsp_valid), 128'd0);
      end else begin
        chk("rr_valid", 128'(rsp_valid), 128'd1);
        chk("rr_id", 128'(rsp_id), 128'((c - 1) % 4));
        chk("rr_sum", 128'(rsp_sum), 128'(100 + 3 * ((c - 1) % 4)));
      end
    end
    req_valid = '0;
    tick();
    chk("rr_last_id", 128'(rsp_id), 128'd3);
    chk("rr_last_sum", 128'(rsp_sum), 128'd109);
    tick();
    chk("rr_drain_valid", 128'(rsp_valid), 128'd0);

    // Backpressure on a stream from requester 2
    set_op(2, 127'd1000, 127'd0);
    req_valid = 4'b0100;
    #1;
    chk("bp_ready0", 128'(req_ready), 128'b0100);
    tick();
    chk("bp_valid0", 128'(rsp_valid), 128'd0);
    set_op(2, 127'd1001, 127'd0);
    #1;
    chk("bp_ready1", 128'(req_ready), 128'b0100);
    tick();
    set_op(2, 127'd1002, 127'd0);
    rsp_ready = 1'b0;
    #1;
    chk("bp_stall_ready", 128'(req_ready), 128'd0);
    chk("bp_stall_id", 128'(rsp_id), 128'd2);
    chk("bp_stall_sum", 128'(rsp_sum), 128'd1000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_valid", 128'(rsp_valid), 128'd1);
      chk("bp_hold_sum", 128'(rsp_sum), 128'd1000);
      chk("bp_hold_ready", 128'(req_ready), 128'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 128'(req_ready), 128'b0100);
    tick();
    req_valid = '0;
    chk("bp_out1_valid", 128'(rsp_valid), 128'd1);
    chk("bp_out1_sum", 128'(rsp_sum), 128'd1001);
    tick();
    chk("bp_out2_valid", 128'(rsp_valid), 128'd1);
    chk("bp_out2_sum", 128'(rsp_sum), 128'd1002);
    tick();
    chk("bp_end_valid", 128'(rsp_valid), 128'd0);

`ifdef ADDER_ARB_STATS_EN
    chk("stat_stalls", 128'(stat_stalls), 128'd3);
    chk("stat_accepts", 128'(stat_accepts), 128'd11);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
